// File: rtl/t_pulse_gen_pkg.sv
// Shared definitions for the push-button to toggle-pulse front end:
// FSM state encoding and parameter defaults.
package t_pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int CNT_W_DEF           = 16;

   // Both debounce phases report busy so downstream logic can tell a settling input
   // from a stable one.
   function automatic logic is_wait(input state_t st);
      return (st == PRESS_WAIT) || (st == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/t_pulse_gen_btn_sync.sv
// Multi-flop synchroniser for one asynchronous level input; reusable for any
// button or slow status line crossing into clk.
module btn_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stage;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/t_pulse_gen.sv
// Push-button front end: synchronise, debounce, and emit one single-cycle t pulse
// per accepted press to drive a downstream toggle flip-flop.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   IDLE         | button released and stable, waiting for a press
//   PRESS_WAIT   | input went high, counting stable-high cycles before accepting
//   HELD         | press accepted, btn_level = 1, waiting for release
//   RELEASE_WAIT | input went low, counting stable-low cycles before releasing
module t_pulse_gen
   import t_pulse_gen_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   input  logic en,
   output logic t,
   output logic btn_level,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   btn_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_in),
      .q     (s)
   );

   // The counter only advances below CNT_LAST and is cleared on every entry to a
   // wait state, so it can never wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         t         <= 1'b0;
         btn_level <= 1'b0;
         busy      <= 1'b0;
      end else begin
         t <= 1'b0;
         unique case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
                  busy  <= is_wait(PRESS_WAIT);
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
                  busy  <= is_wait(IDLE);
               end else if (cnt == CNT_LAST) begin
                  state     <= HELD;
                  btn_level <= 1'b1;
                  t         <= en;
                  busy      <= is_wait(HELD);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
                  busy  <= is_wait(RELEASE_WAIT);
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= HELD;
                  busy  <= is_wait(HELD);
               end else if (cnt == CNT_LAST) begin
                  state     <= IDLE;
                  btn_level <= 1'b0;
                  busy      <= is_wait(IDLE);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
